// File: rtl/throw_traj_gen.sv
// throw_traj_gen: projectile trajectory generator with per-tick integration and outcome detection
module throw_traj_gen #(
    parameter int TICK_CYCLES = 65000,
    parameter int POS_W       = 12,
    parameter int FORCE_W     = 10,
    parameter int V0          = 27,
    parameter int GRAVITY     = 1,
    parameter int FORCE_NUM   = 23,
    parameter int START_X     = 140,
    parameter int START_Y     = 350,
    parameter int GROUND_Y    = 243,
    parameter int X_MAX       = 1023,
    parameter int WALL_XL     = 490,
    parameter int WALL_XR     = 534,
    parameter int WALL_TOP    = 527,
    parameter int TGT_XL      = 867,
    parameter int TGT_XR      = 1023,
    parameter int TGT_YB      = 243,
    parameter int TGT_YT      = 341,
    parameter int MAX_TICKS   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     dir_i,
    input  logic [FORCE_W-1:0]       throw_force_i,
    input  logic signed [7:0]        wind_i,
    output logic signed [POS_W-1:0]  x_pos_o,
    output logic signed [POS_W-1:0]  y_pos_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     hit_target_o,
    output logic [2:0]               result_o
);
    localparam int CW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam int NW = MAX_TICKS > 1 ? $clog2(MAX_TICKS + 1) : 1;
    localparam int IW = FORCE_W + 9;
    typedef logic signed [POS_W-1:0] pos_t;
    typedef enum logic [1:0] {IDLE, FLIGHT, RESULT} state_t;
    localparam pos_t SX   = pos_t'(START_X);
    localparam pos_t SY   = pos_t'(START_Y);
    localparam pos_t VY0  = pos_t'(V0);
    localparam pos_t GRV  = pos_t'(GRAVITY);
    localparam pos_t GY   = pos_t'(GROUND_Y);
    localparam pos_t XM   = pos_t'(X_MAX);
    localparam pos_t WXL  = pos_t'(WALL_XL);
    localparam pos_t WXR  = pos_t'(WALL_XR);
    localparam pos_t WTOP = pos_t'(WALL_TOP);
    localparam pos_t TXL  = pos_t'(TGT_XL);
    localparam pos_t TXR  = pos_t'(TGT_XR);
    localparam pos_t TYB  = pos_t'(TGT_YB);
    localparam pos_t TYT  = pos_t'(TGT_YT);
    localparam logic [CW-1:0] TLAST = CW'(TICK_CYCLES - 1);
    localparam logic [NW-1:0] NMAX = NW'(MAX_TICKS);
    localparam logic signed [IW-1:0] FNUM = IW'(FORCE_NUM);
    localparam logic [2:0] R_NONE = 3'd0, R_HIT = 3'd1, R_WALL = 3'd2, R_GND = 3'd3, R_OUT = 3'd4, R_TO = 3'd5;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    pos_t            x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
    logic [NW-1:0]   n_q, n_d;
    logic [2:0]      res_q, res_d;
    logic            done_q, done_d, hit_q, hit_d, chk_q, chk_d;
    logic            tick;
    logic signed [IW-1:0] f_s, w_s, prod, vx_full;
    pos_t            vx_new;
    logic            in_tgt, in_wall, on_gnd, is_out;
    logic [2:0]      code;

    assign tick    = cnt_q == TLAST;
    assign f_s     = $signed({{(IW-FORCE_W){1'b0}}, throw_force_i});
    assign w_s     = $signed({{(IW-8){wind_i[7]}}, wind_i});
    assign prod    = f_s * FNUM + w_s * f_s;
    assign vx_full = prod >>> 7;
    assign vx_new  = dir_i ? pos_t'(-vx_full) : pos_t'(vx_full);
    assign in_tgt  = x_q >= TXL && x_q <= TXR && y_q >= TYB && y_q <= TYT;
    assign in_wall = x_q >= WXL && x_q <= WXR && y_q <= WTOP;
    assign on_gnd  = y_q <= GY;
    assign is_out  = x_q[POS_W-1] || x_q > XM;
    assign code    = in_tgt ? R_HIT : in_wall ? R_WALL : on_gnd ? R_GND : is_out ? R_OUT : (n_q == NMAX) ? R_TO : R_NONE;

    assign x_pos_o      = x_q;
    assign y_pos_o      = y_q;
    assign busy_o       = state_q == FLIGHT;
    assign done_o       = done_q;
    assign hit_target_o = hit_q;
    assign result_o     = res_q;

    // next-state: launch latch in IDLE, per-tick integration, outcome check the cycle after a tick; abort overrides all
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        n_d     = n_q;
        res_d   = res_q;
        done_d  = 1'b0;
        hit_d   = 1'b0;
        chk_d   = 1'b0;
        case (state_q)
            IDLE: begin
                x_d = SX;
                y_d = SY;
                if (start_i) begin
                    state_d = FLIGHT;
                    cnt_d   = '0;
                    vx_d    = vx_new;
                    vy_d    = VY0;
                    n_d     = '0;
                    res_d   = R_NONE;
                end
            end
            FLIGHT: begin
                if (tick) begin
                    x_d   = x_q + vx_q;
                    y_d   = y_q + vy_q;
                    vy_d  = vy_q - GRV;
                    n_d   = n_q + NW'(1);
                    chk_d = 1'b1;
                end
                if (chk_q && code != R_NONE) begin
                    state_d = RESULT;
                    res_d   = code;
                    done_d  = 1'b1;
                    hit_d   = code == R_HIT;
                end
            end
            RESULT: begin
                if (!start_i) begin
                    state_d = IDLE;
                    x_d     = SX;
                    y_d     = SY;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            x_d     = SX;
            y_d     = SY;
            res_d   = res_q;
            done_d  = 1'b0;
            hit_d   = 1'b0;
            chk_d   = 1'b0;
        end
    end

    // state and datapath registers, asynchronously reset to the launch point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= SX;
            y_q     <= SY;
            vx_q    <= '0;
            vy_q    <= '0;
            n_q     <= '0;
            res_q   <= R_NONE;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            chk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            n_q     <= n_d;
            res_q   <= res_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            chk_q   <= chk_d;
        end
    end
endmodule

// File: tb/tb_throw_traj_gen.sv
// tb_throw_traj_gen: directed vector bench for throw_traj_gen (default, priority-box and short-timeout instances)
module tb_throw_traj_gen;
    localparam int TC = 4;

    typedef struct {
        int sel;
        int frc;
        int wnd;
        int dr;
        int res;
        int x;
        int y;
        int k;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, dir = 1'b0;
    logic [9:0] frc = '0;
    logic signed [7:0] wind = '0;
    logic [2:0][11:0] xo, yo;
    logic [2:0][2:0] ro;
    logic [2:0] bo, dn, ho;
    int nvec = 0, nerr = 0;
    vec_t tv[12];

    always #5 clk = ~clk;

    throw_traj_gen #(.TICK_CYCLES(TC)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .dir_i(dir),
        .throw_force_i(frc), .wind_i(wind), .x_pos_o(xo[0]), .y_pos_o(yo[0]),
        .busy_o(bo[0]), .done_o(dn[0]), .hit_target_o(ho[0]), .result_o(ro[0]));

    throw_traj_gen #(.TICK_CYCLES(TC), .TGT_XL(480), .TGT_XR(540), .TGT_YB(200), .TGT_YT(240)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .dir_i(dir),
        .throw_force_i(frc), .wind_i(wind), .x_pos_o(xo[1]), .y_pos_o(yo[1]),
        .busy_o(bo[1]), .done_o(dn[1]), .hit_target_o(ho[1]), .result_o(ro[1]));

    throw_traj_gen #(.TICK_CYCLES(TC), .MAX_TICKS(3)) dut2 (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .dir_i(dir),
        .throw_force_i(frc), .wind_i(wind), .x_pos_o(xo[2]), .y_pos_o(yo[2]),
        .busy_o(bo[2]), .done_o(dn[2]), .hit_target_o(ho[2]), .result_o(ro[2]));

    task automatic chk(input string nm, input int act, input int want);
        nvec++;
        if (act != want) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_all;
        abort = 1'b1;
        start = 1'b0;
        step;
        abort = 1'b0;
        step;
    endtask

    task automatic launch(input int f, input int w, input int d);
        frc   = f[9:0];
        wind  = w[7:0];
        dir   = d[0];
        start = 1'b1;
        step;
    endtask

    initial begin
        int s, cyc, seen;
        tv[0]  = '{0,    0,   0, 0, 3,  140, 232, 59};
        tv[1]  = '{0,  512,   0, 0, 2,  508, 452,  4};
        tv[2]  = '{0,  512,   0, 1, 4,  -44, 403,  2};
        tv[3]  = '{0, 1023,  50, 0, 4, 1306, 403,  2};
        tv[4]  = '{0, 1023,  50, 1, 4, -443, 377,  1};
        tv[5]  = '{0,   73,   0, 0, 1,  868, 322, 56};
        tv[6]  = '{0,  100,  -6, 0, 1,  868, 322, 56};
        tv[7]  = '{0,   34,   0, 0, 2,  494, 232, 59};
        tv[8]  = '{1,   34,   0, 0, 1,  494, 232, 59};
        tv[9]  = '{2,    0,   0, 0, 5,  140, 428,  3};
        tv[10] = '{0,  100,  -6, 1, 4,   -3, 592, 11};
        tv[11] = '{0,  200, -50, 0, 4,  -32, 452,  4};

        repeat (2) @(negedge clk);
        chk("reset_x", $signed(xo[0]), 140);
        chk("reset_y", $signed(yo[0]), 350);
        chk("reset_busy", bo[0], 0);
        chk("reset_done", dn[0], 0);
        chk("reset_hit", ho[0], 0);
        chk("reset_result", ro[0], 0);
        rst = 1'b0;
        step;
        chk("idle_busy", bo[0], 0);

        clear_all;
        launch(0, 0, 0);
        repeat (108) step;
        chk("peak_y_t27", $signed(yo[0]), 728);
        chk("peak_x_t27", $signed(xo[0]), 140);
        chk("busy_t27", bo[0], 1);
        repeat (112) step;
        chk("y_t55", $signed(yo[0]), 350);
        repeat (16) step;
        chk("y_t59", $signed(yo[0]), 232);
        chk("done_not_yet_t59", dn[0], 0);
        step;
        chk("done_ground", dn[0], 1);
        chk("result_ground", ro[0], 3);
        chk("busy_ground", bo[0], 0);
        start = 1'b0;
        step;

        for (int i = 0; i < 12; i++) begin
            s = tv[i].sel;
            clear_all;
            launch(tv[i].frc, tv[i].wnd, tv[i].dr);
            chk($sformatf("v%0d_busy_accept", i), bo[s], 1);
            chk($sformatf("v%0d_result_cleared", i), ro[s], 0);
            cyc = 0;
            while (!dn[s] && cyc < 400) begin
                step;
                cyc++;
            end
            chk($sformatf("v%0d_cycles_to_done", i), cyc, 4 * tv[i].k + 1);
            chk($sformatf("v%0d_result", i), ro[s], tv[i].res);
            chk($sformatf("v%0d_x", i), $signed(xo[s]), tv[i].x);
            chk($sformatf("v%0d_y", i), $signed(yo[s]), tv[i].y);
            chk($sformatf("v%0d_hit_pulse", i), ho[s], tv[i].res == 1 ? 1 : 0);
            step;
            step;
            chk($sformatf("v%0d_done_single", i), dn[s], 0);
            chk($sformatf("v%0d_hit_single", i), ho[s], 0);
            chk($sformatf("v%0d_no_restart", i), bo[s], 0);
            chk($sformatf("v%0d_x_held", i), $signed(xo[s]), tv[i].x);
            chk($sformatf("v%0d_result_held", i), ro[s], tv[i].res);
            start = 1'b0;
            step;
            chk($sformatf("v%0d_x_home", i), $signed(xo[s]), 140);
            chk($sformatf("v%0d_y_home", i), $signed(yo[s]), 350);
            chk($sformatf("v%0d_result_kept", i), ro[s], tv[i].res);
        end

        clear_all;
        launch(512, 0, 0);
        chk("abort_pre_result_cleared", ro[0], 0);
        repeat (5) step;
        chk("abort_pre_x", $signed(xo[0]), 232);
        abort = 1'b1;
        step;
        chk("abort_busy", bo[0], 0);
        chk("abort_x", $signed(xo[0]), 140);
        chk("abort_y", $signed(yo[0]), 350);
        chk("abort_done", dn[0], 0);
        chk("abort_result", ro[0], 0);
        abort = 1'b0;
        start = 1'b0;
        seen = 0;
        repeat (20) begin
            step;
            seen = seen | int'(dn[0]);
        end
        chk("abort_no_done", seen, 0);

        clear_all;
        launch(1023, 50, 1);
        repeat (4) step;
        chk("abort_outcome_pre_x", $signed(xo[0]), -443);
        start = 1'b0;
        abort = 1'b1;
        step;
        chk("abort_outcome_done", dn[0], 0);
        chk("abort_outcome_result", ro[0], 0);
        chk("abort_outcome_x", $signed(xo[0]), 140);
        abort = 1'b0;
        step;
        chk("abort_outcome_done_after", dn[0], 0);

        clear_all;
        launch(512, 0, 0);
        repeat (8) step;
        chk("rst_pre_x", $signed(xo[0]), 324);
        chk("rst_pre_y", $signed(yo[0]), 403);
        chk("rst_pre_busy", bo[0], 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_x", $signed(xo[0]), 140);
        chk("async_rst_y", $signed(yo[0]), 350);
        chk("async_rst_busy", bo[0], 0);
        chk("async_rst_result", ro[0], 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step;
        chk("post_rst_busy", bo[0], 0);
        chk("post_rst_x", $signed(xo[0]), 140);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
